// File: rtl/keypad_scanner_pkg.sv
// Shared keypad constants, FSM encodings and small scan helpers for the keypad scanner.
package keypad_scanner_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEY_W    = 4;

   localparam logic [0:0] ST_RELEASED = 1'b0;
   localparam logic [0:0] ST_HELD     = 1'b1;

   typedef struct packed {
      logic             valid;
      logic [KEY_W-1:0] code;
   } scan_key_t;

   localparam scan_key_t KEY_NONE = '0;

   // Number of low rows in one column, saturated at 2 (2 means "two or more").
   function automatic logic [1:0] row_count(input logic [NUM_ROWS-1:0] low_rows);
      logic [2:0] n;
      n = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         n = n + {2'b00, low_rows[r]};
      end
      return (n > 3'd1) ? 2'd2 : n[1:0];
   endfunction

   function automatic logic [1:0] row_index(input logic [NUM_ROWS-1:0] low_rows);
      logic [1:0] idx;
      idx = '0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (low_rows[r]) begin
            idx = 2'(r);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchroniser for asynchronous board inputs; idles high to match pulled-up lines.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             CLK_i,
   input  logic             RST_i,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge CLK_i or negedge RST_i) begin
      if (!RST_i) begin
         meta <= '1;
         dout <= '1;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, per-scan key detection, whole-scan debounce
// and a press/release FSM that emits one strobe per newly accepted key.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                CLK_i,
   input  logic                RST_i,
   input  logic [NUM_ROWS-1:0] ROW_i,
   output logic [NUM_COLS-1:0] COL_o,
   output logic [KEY_W-1:0]    KEY_CODE_o,
   output logic                KEY_VALID_o,
   output logic                KEY_HELD_o
);

   localparam int               DWELL_W    = $clog2(SCAN_DIV);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [3:0]       STABLE_TGT = 4'(DEBOUNCE_SCANS);

   logic [NUM_ROWS-1:0] row_sync;
   logic [DWELL_W-1:0]  dwell;
   logic [1:0]          col_idx;
   logic [1:0]          acc_count;
   logic [KEY_W-1:0]    acc_code;
   scan_key_t           candidate;
   logic [3:0]          stable_cnt;
   logic [0:0]          state;

   logic                sample;
   logic                scan_end;
   logic [NUM_ROWS-1:0] low_rows;
   logic [1:0]          col_hits;
   logic [2:0]          hit_sum;
   logic [1:0]          total_hits;
   logic [KEY_W-1:0]    hit_code;
   scan_key_t           result;
   logic                same;
   logic                accept;

   sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
      .CLK_i (CLK_i),
      .RST_i (RST_i),
      .din   (ROW_i),
      .dout  (row_sync)
   );

   assign COL_o = ~(NUM_COLS'(1) << col_idx);

   // Hit count saturates at 2 so any multi-key scan collapses to NONE at evaluation.
   always_comb begin
      sample     = (dwell == DWELL_LAST);
      scan_end   = sample && (col_idx == 2'd3);
      low_rows   = ~row_sync;
      col_hits   = row_count(low_rows);
      hit_sum    = {1'b0, acc_count} + {1'b0, col_hits};
      total_hits = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
      hit_code   = (col_hits == 2'd1) ? {row_index(low_rows), col_idx} : acc_code;
      result     = KEY_NONE;
      if (total_hits == 2'd1) begin
         result = '{valid: 1'b1, code: hit_code};
      end
      same   = (result == candidate);
      accept = scan_end && (same ? (stable_cnt == STABLE_TGT - 4'd1) : (STABLE_TGT == 4'd1));
   end

   always_ff @(posedge CLK_i or negedge RST_i) begin
      if (!RST_i) begin
         dwell     <= '0;
         col_idx   <= '0;
         acc_count <= '0;
         acc_code  <= '0;
      end else if (sample) begin
         dwell   <= '0;
         col_idx <= col_idx + 2'd1;
         if (scan_end) begin
            acc_count <= '0;
            acc_code  <= '0;
         end else begin
            acc_count <= total_hits;
            acc_code  <= hit_code;
         end
      end else begin
         dwell <= dwell + 1'b1;
      end
   end

   always_ff @(posedge CLK_i or negedge RST_i) begin
      if (!RST_i) begin
         candidate  <= KEY_NONE;
         stable_cnt <= '0;
      end else if (scan_end) begin
         if (!same) begin
            candidate  <= result;
            stable_cnt <= 4'd1;
         end else if (stable_cnt != STABLE_TGT) begin
            stable_cnt <= stable_cnt + 4'd1;
         end
      end
   end

   // Re-accepting the code already shown (e.g. after a brief glitch) never re-strobes.
   always_ff @(posedge CLK_i or negedge RST_i) begin
      if (!RST_i) begin
         state       <= ST_RELEASED;
         KEY_CODE_o  <= '0;
         KEY_VALID_o <= 1'b0;
         KEY_HELD_o  <= 1'b0;
      end else begin
         KEY_VALID_o <= 1'b0;
         if (accept) begin
            case (state)
               ST_RELEASED: begin
                  if (result.valid) begin
                     KEY_CODE_o  <= result.code;
                     KEY_VALID_o <= 1'b1;
                     KEY_HELD_o  <= 1'b1;
                     state       <= ST_HELD;
                  end
               end
               ST_HELD: begin
                  if (!result.valid) begin
                     KEY_HELD_o <= 1'b0;
                     state      <= ST_RELEASED;
                  end else if (result.code != KEY_CODE_o) begin
                     KEY_CODE_o  <= result.code;
                     KEY_VALID_o <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (SCAN_DIV=8, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;

   logic       clk;
   logic       rst_n;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys;
   int          checks;
   int          errors;
   int          pulse_count;
   int          width_errs;
   logic        prev_valid;

   keypad_scanner #(
      .SCAN_DIV       (8),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .CLK_i       (clk),
      .RST_i       (rst_n),
      .ROW_i       (row),
      .COL_o       (col),
      .KEY_CODE_o  (key_code),
      .KEY_VALID_o (key_valid),
      .KEY_HELD_o  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A pressed key shorts its row to its column, so the row reads low only while that column is driven.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4+c] && !col[c]) begin
               row[r] = 1'b0;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (key_valid) begin
            pulse_count = pulse_count + 1;
            if (prev_valid) width_errs = width_errs + 1;
         end
         prev_valid = key_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic wait_for_pulse(input int limit, output int lat, output bit seen);
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < limit) begin
         @(negedge clk);
         lat = lat + 1;
         if (key_valid) seen = 1'b1;
      end
   endtask

   task automatic wait_for_release(input int limit, output bit seen);
      int n;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < limit) begin
         @(negedge clk);
         n = n + 1;
         if (!key_held) seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      logic [3:0] e;
      rst_n = 1'b0;
      keys  = '0;
      repeat (3) @(negedge clk);
      checks++; if (col !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col: got %b expected %b", col, 4'b1110); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL reset_code: got %h expected %h", key_code, 4'h0); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL reset_held: got %b expected 0", key_held); end
      rst_n = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      checks++; if (col !== 4'b1110) begin errors++; $display("[TB] FAIL col0_dwell_end: got %b expected %b", col, 4'b1110); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (col !== 4'b1101) begin errors++; $display("[TB] FAIL col1_first: got %b expected %b", col, 4'b1101); end
      for (int k = 2; k <= 8; k++) begin
         repeat (8) @(posedge clk);
         @(negedge clk);
         e = 4'hF;
         e[k%4] = 1'b0;
         checks++; if (col !== e) begin errors++; $display("[TB] FAIL col_rotate_%0d: got %b expected %b", k, col, e); end
      end
      repeat (320) @(negedge clk);
      checks++; if (pulse_count !== 0) begin errors++; $display("[TB] FAIL idle_no_pulse: got %0d expected 0", pulse_count); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL idle_held: got %b expected 0", key_held); end
   endtask

   task automatic test_single_key;
      int start, lat;
      bit seen;
      start = pulse_count;
      @(negedge clk);
      keys[9] = 1'b1;
      wait_for_pulse(200, lat, seen);
      checks++; if (!seen || lat > 131) begin errors++; $display("[TB] FAIL key9_latency: got %0d cycles (seen=%0b) expected <= 131", lat, seen); end
      checks++; if (key_code !== 4'h9) begin errors++; $display("[TB] FAIL key9_code: got %h expected 9", key_code); end
      checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL key9_held: got %b expected 1", key_held); end
      repeat (160) @(negedge clk);
      checks++; if (pulse_count !== start + 1) begin errors++; $display("[TB] FAIL key9_single_pulse: got %0d expected %0d", pulse_count - start, 1); end
      keys[9] = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL key9_release_early: got %b expected 1", key_held); end
      wait_for_release(100, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL key9_release: got held=%b expected 0", key_held); end
      checks++; if (key_code !== 4'h9) begin errors++; $display("[TB] FAIL key9_code_kept: got %h expected 9", key_code); end
      repeat (2) @(negedge clk);
      checks++; if (pulse_count !== start + 1) begin errors++; $display("[TB] FAIL key9_release_no_pulse: got %0d expected %0d", pulse_count - start, 1); end
   endtask

   task automatic test_bounce;
      int start, lat, n;
      bit seen;
      logic [3:0] prev_col;
      start = pulse_count;
      // Phase the bounce against the column rotation so no three consecutive scans agree.
      @(negedge clk);
      prev_col = col;
      n = 0;
      while (col === prev_col && n < 40) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         keys[3] = (i % 2 == 0);
         repeat (20) @(negedge clk);
      end
      keys[3] = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (pulse_count !== start) begin errors++; $display("[TB] FAIL bounce_no_pulse: got %0d expected 0", pulse_count - start); end
      wait_for_pulse(140, lat, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL bounce_steady_pulse: got none within %0d expected 1", lat); end
      checks++; if (key_code !== 4'h3) begin errors++; $display("[TB] FAIL bounce_code: got %h expected 3", key_code); end
      repeat (3) @(negedge clk);
      checks++; if (pulse_count !== start + 1) begin errors++; $display("[TB] FAIL bounce_pulse_count: got %0d expected 1", pulse_count - start); end
      keys = '0;
      wait_for_release(140, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL bounce_release: got held=%b expected 0", key_held); end
   endtask

   task automatic test_rollover;
      int start, lat;
      bit seen;
      start = pulse_count;
      keys[4]  = 1'b1;
      keys[14] = 1'b1;
      repeat (200) @(negedge clk);
      checks++; if (pulse_count !== start) begin errors++; $display("[TB] FAIL rollover_no_pulse: got %0d expected 0", pulse_count - start); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL rollover_held: got %b expected 0", key_held); end
      checks++; if (key_code !== 4'h3) begin errors++; $display("[TB] FAIL rollover_code_kept: got %h expected 3", key_code); end
      keys[14] = 1'b0;
      wait_for_pulse(140, lat, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL rollover_single_pulse: got none within %0d expected 1", lat); end
      checks++; if (key_code !== 4'h4) begin errors++; $display("[TB] FAIL rollover_code: got %h expected 4", key_code); end
      keys = '0;
      wait_for_release(140, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL rollover_release: got held=%b expected 0", key_held); end
   endtask

   task automatic test_back_to_back;
      int start, lat;
      bit seen, held_dropped;
      start = pulse_count;
      keys[5] = 1'b1;
      wait_for_pulse(140, lat, seen);
      checks++; if (!seen || key_code !== 4'h5) begin errors++; $display("[TB] FAIL b2b_first: got %h (seen=%0b) expected 5", key_code, seen); end
      repeat (20) @(negedge clk);
      keys[5]  = 1'b0;
      keys[10] = 1'b1;
      held_dropped = 1'b0;
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < 140) begin
         @(negedge clk);
         lat++;
         if (!key_held) held_dropped = 1'b1;
         if (key_valid) seen = 1'b1;
      end
      checks++; if (!seen || key_code !== 4'hA) begin errors++; $display("[TB] FAIL b2b_second: got %h (seen=%0b) expected a", key_code, seen); end
      checks++; if (held_dropped) begin errors++; $display("[TB] FAIL b2b_held: got dropped expected held throughout"); end
      repeat (3) @(negedge clk);
      checks++; if (pulse_count !== start + 2) begin errors++; $display("[TB] FAIL b2b_pulse_count: got %0d expected 2", pulse_count - start); end
      keys = '0;
      wait_for_release(140, seen);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL b2b_release: got held=%b expected 0", key_held); end
   endtask

   task automatic test_reset_mid;
      int start;
      start = pulse_count;
      keys[7] = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (pulse_count !== start || key_held !== 1'b0) begin errors++; $display("[TB] FAIL mid_debounce_quiet: got pulses=%0d held=%b expected 0 0", pulse_count - start, key_held); end
      rst_n = 1'b0;
      #1;
      checks++; if (col !== 4'b1110) begin errors++; $display("[TB] FAIL midrst_col: got %b expected 1110", col); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL midrst_code: got %h expected 0", key_code); end
      checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags: got valid=%b held=%b expected 0 0", key_valid, key_held); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (95) @(posedge clk);
      @(negedge clk);
      checks++; if (key_valid !== 1'b0 || pulse_count !== start) begin errors++; $display("[TB] FAIL midrst_no_early_pulse: got valid=%b pulses=%0d expected 0 0", key_valid, pulse_count - start); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pulse: got %b expected 1", key_valid); end
      checks++; if (key_code !== 4'h7) begin errors++; $display("[TB] FAIL midrst_code_after: got %h expected 7", key_code); end
      repeat (3) @(negedge clk);
      checks++; if (width_errs !== 0) begin errors++; $display("[TB] FAIL pulse_width: got %0d long pulses expected 0", width_errs); end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      pulse_count = 0;
      width_errs  = 0;
      prev_valid  = 1'b0;
      keys        = '0;
      rst_n       = 1'b0;
      $display("[TB] keypad_scanner directed run");
      test_reset();
      test_single_key();
      test_bounce();
      test_rollover();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
